// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared widths, defaults and scoreboard entry type for hazard_ctrl
package hazard_pkg;

    localparam int HZ_TW       = 2;
    localparam int HZ_NSTAGE   = 3;
    localparam int HZ_MULT_LAT = 5;
    localparam int HZ_DIV_LAT  = 10;

    localparam logic [HZ_TW-1:0] TUSE_NONE = '1;

    typedef struct packed {
        logic [4:0]       waddr;
        logic [HZ_TW-1:0] tnew;
    } sb_entry_t;

    function automatic logic [HZ_TW-1:0] tnew_dec(input logic [HZ_TW-1:0] t);
        return (t == '0) ? '0 : t - HZ_TW'(1);
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_ctr.sv
// rtl/hazard_ctrl_md_busy_ctr.sv - mult/div occupancy down-counter
module md_busy_ctr #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic is_div,
    output logic md_busy
);

    localparam int MAXLAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW     = $clog2(MAXLAT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign md_busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - Tnew/Tuse scoreboard stall and forwarding control
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NSTAGE   = HZ_NSTAGE,
    parameter int TW       = HZ_TW,
    parameter int MULT_LAT = HZ_MULT_LAT,
    parameter int DIV_LAT  = HZ_DIV_LAT
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            d_valid,
    input  logic [4:0]                      d_rs,
    input  logic [4:0]                      d_rt,
    input  logic [TW-1:0]                   d_tuse_rs,
    input  logic [TW-1:0]                   d_tuse_rt,
    input  logic [4:0]                      d_waddr,
    input  logic [TW-1:0]                   d_tnew,
    input  logic                            d_md_start,
    input  logic                            d_md_is_div,
    input  logic                            d_md_use,
    output logic                            en_pc,
    output logic                            en_f2d,
    output logic                            bubble_d2e,
    output logic                            stall,
    output logic [$clog2(NSTAGE+1)-1:0]     fwd_rs_sel,
    output logic [$clog2(NSTAGE+1)-1:0]     fwd_rt_sel,
    output logic                            md_busy
);

    localparam int SW = $clog2(NSTAGE + 1);

    sb_entry_t         sb [NSTAGE];
    logic [NSTAGE-1:0] hit_rs;
    logic [NSTAGE-1:0] hit_rt;

    logic              rs_found, rt_found;
    logic [TW-1:0]     rs_tnew, rt_tnew;
    logic [SW-1:0]     rs_idx, rt_idx;
    logic              rs_stall, rt_stall, md_stall, md_load;

    // Entry 0 takes the D instruction only when it really moves to E.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sb[0] <= '0;
        end else if (d_valid && !stall) begin
            sb[0] <= '{waddr: d_waddr, tnew: d_tnew};
        end else begin
            sb[0] <= '0;
        end
    end

    for (genvar k = 1; k < NSTAGE; k++) begin : g_shift
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sb[k] <= '0;
            end else begin
                sb[k] <= '{waddr: sb[k-1].waddr, tnew: tnew_dec(sb[k-1].tnew)};
            end
        end
    end

    for (genvar k = 0; k < NSTAGE; k++) begin : g_cmp
        assign hit_rs[k] = (sb[k].waddr != 5'd0) && (sb[k].waddr == d_rs);
        assign hit_rt[k] = (sb[k].waddr != 5'd0) && (sb[k].waddr == d_rt);
    end

    // Scan from oldest to youngest so the youngest matching entry wins.
    always_comb begin
        rs_found = 1'b0;
        rs_tnew  = '0;
        rs_idx   = '0;
        rt_found = 1'b0;
        rt_tnew  = '0;
        rt_idx   = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (hit_rs[k]) begin
                rs_found = 1'b1;
                rs_tnew  = sb[k].tnew;
                rs_idx   = SW'(k + 1);
            end
            if (hit_rt[k]) begin
                rt_found = 1'b1;
                rt_tnew  = sb[k].tnew;
                rt_idx   = SW'(k + 1);
            end
        end
    end

    assign rs_stall = rs_found && (d_tuse_rs != TUSE_NONE) && (d_tuse_rs < rs_tnew);
    assign rt_stall = rt_found && (d_tuse_rt != TUSE_NONE) && (d_tuse_rt < rt_tnew);
    assign md_stall = d_valid && (d_md_start || d_md_use) && md_busy;

    assign stall      = d_valid && (rs_stall || rt_stall || md_stall);
    assign en_pc      = !stall;
    assign en_f2d     = !stall;
    assign bubble_d2e = stall;

    assign fwd_rs_sel = (rs_found && rs_tnew == '0) ? rs_idx : '0;
    assign fwd_rt_sel = (rt_found && rt_tnew == '0) ? rt_idx : '0;

    assign md_load = d_valid && d_md_start && !stall;

    md_busy_ctr #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_busy_ctr (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (md_load),
        .is_div  (d_md_is_div),
        .md_busy (md_busy)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized and directed checks of hazard_ctrl against a pipeline model
module tb_hazard_ctrl;

    localparam int NS    = 3;
    localparam int MULTL = 5;
    localparam int DIVL  = 10;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       d_valid;
    logic [4:0] d_rs, d_rt, d_waddr;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_md_start, d_md_is_div, d_md_use;
    logic       en_pc, en_f2d, bubble_d2e, stall, md_busy;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;

    int errors = 0;
    int checks = 0;

    int mw [NS];
    int mt [NS];
    int mdc;

    hazard_ctrl #(.NSTAGE(NS), .TW(2), .MULT_LAT(MULTL), .DIV_LAT(DIVL)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .d_valid     (d_valid),
        .d_rs        (d_rs),
        .d_rt        (d_rt),
        .d_tuse_rs   (d_tuse_rs),
        .d_tuse_rt   (d_tuse_rt),
        .d_waddr     (d_waddr),
        .d_tnew      (d_tnew),
        .d_md_start  (d_md_start),
        .d_md_is_div (d_md_is_div),
        .d_md_use    (d_md_use),
        .en_pc       (en_pc),
        .en_f2d      (en_f2d),
        .bubble_d2e  (bubble_d2e),
        .stall       (stall),
        .fwd_rs_sel  (fwd_rs_sel),
        .fwd_rt_sel  (fwd_rt_sel),
        .md_busy     (md_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int youngest(input int r);
        for (int k = 0; k < NS; k++)
            if (r != 0 && mw[k] == r) return k;
        return -1;
    endfunction

    function automatic bit src_blocks(input int r, input int tuse);
        int k = youngest(r);
        return (k >= 0) && (tuse != 3) && (tuse < mt[k]);
    endfunction

    function automatic int fwd_of(input int r);
        int k = youngest(r);
        return (k >= 0 && mt[k] == 0) ? k + 1 : 0;
    endfunction

    function automatic bit model_stall();
        bit md_hold = (d_md_start || d_md_use) && (mdc != 0);
        return d_valid && (src_blocks(d_rs, d_tuse_rs) || src_blocks(d_rt, d_tuse_rt) || md_hold);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NS; k++) begin
            mw[k] = 0;
            mt[k] = 0;
        end
        mdc = 0;
    endtask

    task automatic model_clock(input bit st);
        for (int k = NS - 1; k > 0; k--) begin
            mw[k] = mw[k-1];
            mt[k] = (mt[k-1] > 0) ? mt[k-1] - 1 : 0;
        end
        mw[0] = (d_valid && !st) ? int'(d_waddr) : 0;
        mt[0] = (d_valid && !st) ? int'(d_tnew) : 0;
        if (d_valid && d_md_start && !st) mdc = d_md_is_div ? DIVL : MULTL;
        else if (mdc > 0) mdc--;
    endtask

    // Called just after a falling edge with D inputs already applied.
    task automatic step();
        bit est;
        est = model_stall();
        #1;
        check("stall", int'(stall), int'(est));
        check("en_pc", int'(en_pc), int'(!est));
        check("en_f2d", int'(en_f2d), int'(!est));
        check("bubble", int'(bubble_d2e), int'(est));
        check("fwd_rs", int'(fwd_rs_sel), fwd_of(d_rs));
        check("fwd_rt", int'(fwd_rt_sel), fwd_of(d_rt));
        check("md_busy", int'(md_busy), int'(mdc != 0));
        @(posedge clk);
        model_clock(est);
        @(negedge clk);
    endtask

    task automatic idle_in();
        d_valid = 0; d_rs = 0; d_rt = 0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
        d_waddr = 0; d_tnew = 0; d_md_start = 0; d_md_is_div = 0; d_md_use = 0;
    endtask

    task automatic issue(input int rs, input int tuse_rs, input int wa, input int tn);
        idle_in();
        d_valid = 1; d_rs = 5'(rs); d_tuse_rs = 2'(tuse_rs); d_waddr = 5'(wa); d_tnew = 2'(tn);
    endtask

    initial begin
        int n;
        idle_in();
        reset_n = 0;
        model_clear();
        repeat (2) @(negedge clk);
        d_valid = 1; d_rs = 5; d_tuse_rs = 0; d_md_use = 1;
        #1;
        check("rst_stall", int'(stall), 0);
        check("rst_en_pc", int'(en_pc), 1);
        check("rst_md_busy", int'(md_busy), 0);
        check("rst_fwd_rs", int'(fwd_rs_sel), 0);
        @(negedge clk);
        idle_in();
        reset_n = 1;

        // load-use on $5
        issue(0, 3, 5, 2); step();
        issue(5, 1, 6, 1);
        #1 check("lu_stall", int'(stall), 1);
        step(); step();
        // beq behind addu $8
        issue(0, 3, 8, 1); step();
        issue(8, 0, 0, 0);
        #1 check("beq_stall", int'(stall), 1);
        step();
        #1 check("beq_fwd", int'(fwd_rs_sel), 2);
        step();
        // duplicate destinations: youngest (E, tnew 0) wins
        issue(0, 3, 3, 2); step();
        issue(0, 3, 3, 0); step();
        issue(3, 0, 0, 0);
        #1 check("dup_stall", int'(stall), 0);
        check("dup_fwd", int'(fwd_rs_sel), 1);
        step();
        // write to $0 never creates a hazard
        issue(0, 3, 0, 2); step();
        issue(0, 0, 0, 0); d_rt = 0; d_tuse_rt = 0;
        #1 check("r0_stall", int'(stall), 0);
        check("r0_fwd", int'(fwd_rs_sel), 0);
        step();
        // div then mflo: stall for DIV_LAT cycles
        issue(0, 3, 0, 0); d_md_start = 1; d_md_is_div = 1; step();
        issue(0, 3, 4, 1); d_md_use = 1;
        n = 0;
        #1;
        while (stall && n < 40) begin
            n++;
            step();
            #1;
        end
        check("div_stall_len", n, DIVL);
        check("div_busy_clear", int'(md_busy), 0);
        step();
        // reset during a div stall clears state asynchronously
        issue(0, 3, 0, 0); d_md_start = 1; d_md_is_div = 1; step();
        issue(0, 3, 0, 0); d_md_use = 1;
        #1 check("pre_rst_stall", int'(stall), 1);
        #1 reset_n = 0;
        #1;
        check("arst_stall", int'(stall), 0);
        check("arst_md_busy", int'(md_busy), 0);
        model_clear();
        @(negedge clk);
        reset_n = 1;
        idle_in();
        step();

        for (int i = 0; i < 600; i++) begin
            idle_in();
            d_valid     = ($urandom_range(0, 99) < 85);
            d_rs        = 5'($urandom_range(0, 4));
            d_rt        = 5'($urandom_range(0, 4));
            d_tuse_rs   = 2'($urandom_range(0, 3));
            d_tuse_rt   = 2'($urandom_range(0, 3));
            d_waddr     = 5'($urandom_range(0, 4));
            d_tnew      = 2'($urandom_range(0, 3));
            d_md_start  = ($urandom_range(0, 99) < 8);
            d_md_is_div = $urandom_range(0, 1) == 1;
            d_md_use    = ($urandom_range(0, 99) < 10);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
